m8_32_byte_sched: RTL and testbench
===================================

// Module: m8_32_byte_sched
// PURPOSE
//  Round-robin byte scheduler feeding the 8->32 serial-to-parallel converter (clk_4f domain).
//  Shares the converter between NUM_REQ byte-stream requesters (lane FIFOs), granting whole 4-byte words.
//  After reset or on request, emits a COM training burst so the converter aligns its word boundary.
//  Drives data_input/valid_input/sinc of the converter directly.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..8)
//  SYNC_WORDS  4      COM words sent per training burst (1..15)
//  COM_SYM     8'hBC  training/alignment symbol
// PORTS
//  clk_4f        in   1          byte clock; sole clock, all logic on posedge
//  reset         in   1          synchronous, active-high
//  enable        in   1          1 = grants allowed; 0 = finish current word, then idle
//  resync        in   1          pulse: run a training burst at next word boundary
//  req_word_rdy  in   NUM_REQ    req i holds >=4 bytes (FIFO almost-empty flag inverted)
//  req_data      in   8*NUM_REQ  head byte of req i, bits [8i+7:8i]
//  req_pop       out  NUM_REQ    one-hot, combinational: consume head byte of req i this cycle
//  data_input    out  8          byte to converter (registered)
//  valid_input   out  1          byte qualifier (registered)
//  sinc          out  1          1 on byte 0 of every word, training words included (registered)
//  grant_id      out  3          index of requester owning the current word (registered)
//  training      out  1          1 while COM burst is on data_input (registered)
// BEHAVIOUR
//  Reset: data_input=0, valid_input=0, sinc=0, grant_id=0, training=0, req_pop=0, rr pointer=0,
//   state=SYNC, byte_cnt=0, sync_cnt=0. First COM byte on data_input the cycle after reset drops.
//  Latency: byte popped at cycle t (req_pop[i]=1, req_data sampled) appears on data_input at t+1.
//  byte_cnt (2 b) counts bytes 0..3 in SYNC and XFER; wraps 3->0; a word is never split.
//  States:
//   SYNC : data_input=COM_SYM, valid=1, training=1; SYNC_WORDS*4 bytes total; no pops.
//          At byte 3 of last word -> XFER if enable & any rdy, else IDLE.
//   IDLE : valid_input=0, data_input=0, sinc=0. Each cycle: resync -> SYNC;
//          else enable & any rdy -> XFER (arbitrate this cycle, pop byte 0 same cycle).
//   XFER : req_pop[g]=1 for 4 consecutive cycles; valid=1. At byte 3: resync pending -> SYNC;
//          else enable & any rdy -> XFER back-to-back (no bubble); else IDLE.
//  Arbitration: round-robin, search starts at (last grant+1) mod NUM_REQ; rr pointer updates on
//   each grant. Decision only at word boundary; req_word_rdy changes mid-word are ignored.
//  resync: latched into resync_pend when seen in any state; taken at next boundary (IDLE immediately,
//   XFER after byte 3, SYNC restarts sync_cnt at next byte-3). Cleared on entry to SYNC.
//   resync and arbitration on the same boundary: resync wins, no grant, rr pointer unchanged.
//  enable low mid-word: current word completes; no new grant. Training ignores enable.
//  Requester contract: rdy=1 guarantees 4 poppable bytes; scheduler never pops when rdy was 0 at grant.
//  Reset mid-word: word abandoned, outputs to reset values next cycle, training restarts.
// STRUCTURE
//  Shared header phy_defines.vh: COM_SYM value, state encodings (SYNC=2'd0, IDLE=2'd1, XFER=2'd2),
//   BYTES_PER_WORD=4.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer in, one-hot grant + index out, combinational.
//  Top: FSM, byte_cnt, sync_cnt, resync_pend, output registers, req_data mux.
// TESTING (clk_4f; feed data_input/valid_input/sinc to m8_32, check data_8_32 as well)
//  1 reset 3 cycles, no rdy -> 16 bytes 0xBC valid=1, sinc every 4th byte, training=1; then valid=0.
//  2 after sync, req0 rdy with 01,02,03,04 -> pops cycles 0..3, data_input 01..04 one cycle later;
//    converter data_8_32 = 0x01020304 (byte order per converter), grant_id=0.
//  3 all 4 rdy continuously -> grants 0,1,2,3,0 each 4 bytes, zero idle cycles, sinc period 4.
//  4 resync pulsed on byte 1 of req2 word -> bytes 2,3 of req2 still sent, then 16 COM bytes,
//    then grant req3 (rr pointer not disturbed).
//  5 enable dropped on byte 0 -> word finishes, valid_input=0 next; enable high again -> grant resumes.
//  6 reset asserted on byte 2 of a word -> next cycle all outputs 0/reset values, training restarts.

Source files
------------

// File: rtl/m8_32_byte_sched_pkg.sv
// Shared constants and types for the 8->32 byte scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package m8_32_byte_sched_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] COM_SYM_DEF    = 8'hBC;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Index following idx in round-robin order over num_req requesters.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int num_req);
    return (int'(idx) == num_req - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/m8_32_byte_sched_if.sv
// Requester-side and converter-side signals of the byte scheduler.
// Latency: n/a (wiring only).
// Backpressure: requesters advertise whole words via req_word_rdy; scheduler pulls with req_pop.
interface m8_32_byte_sched_if #(
  parameter int NUM_REQ = 4
);

  logic                   enable;
  logic                   resync;
  logic [NUM_REQ-1:0]     req_word_rdy;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_pop;
  logic [7:0]             data_input;
  logic                   valid_input;
  logic                   sinc;
  logic [2:0]             grant_id;
  logic                   training;

  // Scheduler side.
  modport master (
    input  enable, resync, req_word_rdy, req_data,
    output req_pop, data_input, valid_input, sinc, grant_id, training
  );

  // Environment side: requester FIFOs, control and the converter.
  modport slave (
    output enable, resync, req_word_rdy, req_data,
    input  req_pop, data_input, valid_input, sinc, grant_id, training
  );

endinterface

// File: rtl/m8_32_byte_sched_rr_arbiter.sv
// Round-robin picker: first requesting index at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; gnt_vld low when no request is present.
module m8_32_byte_sched_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               gnt_vld
);

  // Scan offsets 0..NUM_REQ-1 from ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = 3'd0;
    gnt_vld = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_vld && req[i] && (i == ((int'(ptr) + off) % NUM_REQ))) begin
          gnt_vld = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/m8_32_byte_sched.sv
// Round-robin byte scheduler feeding the 8->32 converter, with COM training bursts.
// Latency: byte popped in cycle t is on data_input in cycle t+1.
// Backpressure: only whole words are granted to requesters whose req_word_rdy is set; idles otherwise.
module m8_32_byte_sched
  import m8_32_byte_sched_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter int         SYNC_WORDS = 4,
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF
) (
  input logic                 clk_4f,
  input logic                 reset,
  m8_32_byte_sched_if.master  bus
);

  state_e             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [3:0]         sync_cnt_q, sync_cnt_d;
  logic               resync_pend_q, resync_pend_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               sinc_q, sinc_d;
  logic               training_q, training_d;
  logic [2:0]         grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [2:0]         arb_idx;
  logic               arb_vld;

  logic               pop_en;
  logic [2:0]         pop_idx;
  logic [NUM_REQ-1:0] pop_oh;
  logic [7:0]         sel_byte;
  logic               resync_eff;
  logic               can_grant;
  logic               last_byte;

  m8_32_byte_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.req_word_rdy),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Head byte of whichever requester is being popped this cycle.
  always_comb begin
    sel_byte = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == pop_idx) sel_byte = bus.req_data[8*i +: 8];
    end
  end

  // Next-state, word-boundary decisions and next output register values.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    sync_cnt_d    = sync_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    grant_id_d    = grant_id_q;
    data_d        = 8'd0;
    valid_d       = 1'b0;
    sinc_d        = 1'b0;
    training_d    = 1'b0;
    pop_en        = 1'b0;
    pop_idx       = gnt_q;
    pop_oh        = '0;
    resync_eff    = bus.resync | resync_pend_q;
    resync_pend_d = resync_eff;
    can_grant     = bus.enable & arb_vld;
    last_byte     = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

    case (state_q)
      ST_SYNC: begin
        data_d     = COM_SYM;
        valid_d    = 1'b1;
        training_d = 1'b1;
        sinc_d     = (byte_cnt_q == 2'd0);
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (last_byte) begin
          if (resync_eff) begin
            // Restart the burst from its first word.
            sync_cnt_d    = 4'd0;
            resync_pend_d = 1'b0;
          end else if (sync_cnt_q == 4'(SYNC_WORDS - 1)) begin
            sync_cnt_d = 4'd0;
            if (can_grant) begin
              state_d  = ST_XFER;
              gnt_d    = arb_idx;
              rr_ptr_d = rr_next(arb_idx, NUM_REQ);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end
      end

      ST_IDLE: begin
        byte_cnt_d = 2'd0;
        if (resync_eff) begin
          state_d       = ST_SYNC;
          sync_cnt_d    = 4'd0;
          resync_pend_d = 1'b0;
        end else if (can_grant) begin
          // The grant cycle is also byte 0 of the new word.
          pop_en     = 1'b1;
          pop_idx    = arb_idx;
          pop_oh     = arb_gnt;
          gnt_d      = arb_idx;
          rr_ptr_d   = rr_next(arb_idx, NUM_REQ);
          state_d    = ST_XFER;
          byte_cnt_d = 2'd1;
        end
      end

      ST_XFER: begin
        pop_en     = 1'b1;
        pop_idx    = gnt_q;
        for (int i = 0; i < NUM_REQ; i++) pop_oh[i] = (3'(i) == gnt_q);
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (last_byte) begin
          if (resync_eff) begin
            state_d       = ST_SYNC;
            sync_cnt_d    = 4'd0;
            resync_pend_d = 1'b0;
          end else if (can_grant) begin
            gnt_d    = arb_idx;
            rr_ptr_d = rr_next(arb_idx, NUM_REQ);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d    = ST_SYNC;
        byte_cnt_d = 2'd0;
        sync_cnt_d = 4'd0;
      end
    endcase

    if (pop_en) begin
      data_d     = sel_byte;
      valid_d    = 1'b1;
      sinc_d     = (byte_cnt_q == 2'd0);
      grant_id_d = pop_idx;
    end
  end

  // Pops are suppressed while reset is held so no FIFO loses a byte.
  assign bus.req_pop = reset ? '0 : pop_oh;

  // All state and output registers.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      byte_cnt_q    <= 2'd0;
      sync_cnt_q    <= 4'd0;
      resync_pend_q <= 1'b0;
      rr_ptr_q      <= 3'd0;
      gnt_q         <= 3'd0;
      data_q        <= 8'd0;
      valid_q       <= 1'b0;
      sinc_q        <= 1'b0;
      training_q    <= 1'b0;
      grant_id_q    <= 3'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      resync_pend_q <= resync_pend_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      sinc_q        <= sinc_d;
      training_q    <= training_d;
      grant_id_q    <= grant_id_d;
    end
  end

  assign bus.data_input  = data_q;
  assign bus.valid_input = valid_q;
  assign bus.sinc        = sinc_q;
  assign bus.training    = training_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_m8_32_byte_sched.sv
// Bench for the byte scheduler: directed scenarios followed by random traffic.
// Latency: expected outputs come from a word-level plan model one cycle behind the pops.
// Backpressure: requester FIFOs are emulated with byte arrays and fill levels.
module tb_m8_32_byte_sched;

  localparam int         NR    = 4;
  localparam int         SW    = 4;
  localparam logic [7:0] COM   = 8'hBC;
  localparam int         DEPTH = 2048;

  logic clk_4f = 1'b0;
  logic reset;

  m8_32_byte_sched_if #(.NUM_REQ(NR)) bus();

  m8_32_byte_sched #(
    .NUM_REQ    (NR),
    .SYNC_WORDS (SW),
    .COM_SYM    (COM)
  ) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_4f = ~clk_4f;

  // One planned output cycle: a byte of a granted word, a COM byte, or an idle slot.
  typedef struct {
    bit       word;
    bit       com;
    int       idx;
    bit [2:0] g;
    bit [7:0] d;
  } ent_t;

  ent_t     plan[$];
  bit       rs_flag;
  int       train_left;
  int       start_ptr;
  bit [2:0] last_g;
  int       mcons[NR];
  bit [7:0] src[NR][DEPTH];
  int       avail[NR];
  int       rd[NR];
  int       total = 0;
  int       bad = 0;
  bit [31:0] asm_word;
  bit [31:0] last_word;
  int       asm_cnt;
  int       com_seen;
  bit       found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_com();
    for (int k = 0; k < 4; k++)
      plan.push_back('{word: 1'b0, com: 1'b1, idx: k, g: 3'd0, d: COM});
    train_left--;
  endtask

  task automatic push_word(input int g);
    for (int k = 0; k < 4; k++)
      plan.push_back('{word: 1'b1, com: 1'b0, idx: k, g: 3'(g), d: src[g][mcons[g] + k]});
    mcons[g] += 4;
    start_ptr = (g + 1) % NR;
  endtask

  // First ready requester at or after start_ptr, cyclically.
  function automatic int pick(input bit [NR-1:0] r);
    bit [NR-1:0] t;
    for (int off = 0; off < NR; off++) begin
      t = r >> ((start_ptr + off) % NR);
      if (t[0]) return (start_ptr + off) % NR;
    end
    return 0;
  endfunction

  // What follows a finished word: training first, then a grant, else nothing planned.
  task automatic boundary(input bit en, input bit [NR-1:0] r);
    if (rs_flag) begin
      rs_flag    = 1'b0;
      train_left = SW;
      push_com();
    end else if (train_left > 0) begin
      push_com();
    end else if (en && r != '0) begin
      push_word(pick(r));
    end
  endtask

  task automatic model_cycle(input bit rst, input bit en, input bit rs,
                             input bit [NR-1:0] r, output ent_t cur);
    ent_t idle_e;
    idle_e = '{word: 1'b0, com: 1'b0, idx: 0, g: last_g, d: 8'd0};
    if (rst) begin
      // Bytes of an abandoned word that were never popped stay in their FIFO.
      foreach (plan[k]) if (plan[k].word) mcons[plan[k].g]--;
      plan.delete();
      rs_flag    = 1'b0;
      start_ptr  = 0;
      last_g     = 3'd0;
      train_left = SW;
      push_com();
      cur = '{word: 1'b0, com: 1'b0, idx: 0, g: 3'd0, d: 8'd0};
      return;
    end
    rs_flag = rs_flag | rs;
    if (plan.size() > 0) begin
      cur = plan.pop_front();
      if (plan.size() == 0) boundary(en, r);
    end else if (rs_flag) begin
      rs_flag    = 1'b0;
      train_left = SW;
      push_com();
      cur = idle_e;
    end else if (en && r != '0) begin
      push_word(pick(r));
      cur = plan.pop_front();
    end else begin
      cur = idle_e;
    end
    if (cur.word) last_g = cur.g;
    else          cur.g  = last_g;
  endtask

  task automatic step(input bit rst, input bit en, input bit rs);
    ent_t        cur;
    bit [NR-1:0] r;
    bit [NR-1:0] pop_obs;
    bit [NR-1:0] exp_pop;
    reset      = rst;
    bus.enable = en;
    bus.resync = rs;
    for (int i = 0; i < NR; i++) begin
      r[i] = (avail[i] - rd[i] >= 4);
      bus.req_data[8*i +: 8] = src[i][rd[i]];
    end
    bus.req_word_rdy = r;
    #2;
    model_cycle(rst, en, rs, r, cur);
    exp_pop = cur.word ? ({{(NR-1){1'b0}}, 1'b1} << cur.g) : '0;
    pop_obs = bus.req_pop;
    chk("req_pop", 32'(pop_obs), 32'(exp_pop));
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < NR; i++) if (pop_obs[i]) rd[i]++;
    chk("valid_input", 32'(bus.valid_input), 32'(cur.word | cur.com));
    chk("data_input",  32'(bus.data_input),  32'(cur.word ? cur.d : (cur.com ? COM : 8'd0)));
    chk("sinc",        32'(bus.sinc),        32'((cur.word | cur.com) && cur.idx == 0));
    chk("training",    32'(bus.training),    32'(cur.com));
    chk("grant_id",    32'(bus.grant_id),    32'(cur.g));
    if (bus.valid_input && bus.training && bus.data_input == COM) com_seen++;
    if (bus.valid_input && !bus.training) begin
      if (bus.sinc) begin
        asm_cnt  = 0;
        asm_word = '0;
      end
      asm_word = {asm_word[23:0], bus.data_input};
      asm_cnt++;
      if (asm_cnt == 4) last_word = asm_word;
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < DEPTH; k++) src[i][k] = 8'($urandom);
      avail[i] = 0;
      rd[i]    = 0;
      mcons[i] = 0;
    end
    asm_cnt = 0; asm_word = '0; last_word = '0;
    rs_flag = 1'b0; train_left = 0; start_ptr = 0; last_g = 3'd0;
    bus.req_data = '0;

    // Reset for 3 cycles, no requester ready: full COM burst then idle.
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0);
    com_seen = 0;
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 1'b0);
    chk("p1_com_count", 32'(com_seen), 32'(SW * 4));

    // Single word from requester 0.
    src[0][0] = 8'h01; src[0][1] = 8'h02; src[0][2] = 8'h03; src[0][3] = 8'h04;
    avail[0] = 4;
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1, 1'b0);
    chk("p2_word", last_word, 32'h01020304);
    chk("p2_grant", 32'(bus.grant_id), 32'd0);

    // Every requester ready: back-to-back round-robin words.
    for (int i = 0; i < NR; i++) avail[i] = 100000;
    for (int n = 0; n < 24; n++) step(1'b0, 1'b1, 1'b0);

    // Resync on byte 1 of a requester-2 word.
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (plan.size() > 0 && plan[0].word && plan[0].g == 3'd2 && plan[0].idx == 1) begin
        step(1'b0, 1'b1, 1'b1);
        found = 1'b1;
      end else begin
        step(1'b0, 1'b1, 1'b0);
      end
    end
    chk("p4_resync_hit", 32'(found), 32'd1);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.valid_input && bus.sinc && !bus.training) found = 1'b1;
    end
    chk("p4_first_after_train", 32'(found), 32'd1);
    chk("p4_grant_after_train", 32'(bus.grant_id), 32'd3);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1, 1'b0);

    // Enable dropped on byte 0: word completes, then idle until enable returns.
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (plan.size() > 0 && plan[0].word && plan[0].idx == 0) begin
        step(1'b0, 1'b0, 1'b0);
        found = 1'b1;
      end else begin
        step(1'b0, 1'b1, 1'b0);
      end
    end
    chk("p5_drop_hit", 32'(found), 32'd1);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0);
    chk("p5_idle_after_word", 32'(bus.valid_input), 32'd0);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) step(1'b0, 1'b1, 1'b0);

    // Reset on byte 2 of a word.
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (plan.size() > 0 && plan[0].word && plan[0].idx == 2) begin
        step(1'b1, 1'b1, 1'b0);
        found = 1'b1;
      end else begin
        step(1'b0, 1'b1, 1'b0);
      end
    end
    chk("p6_reset_hit", 32'(found), 32'd1);
    chk("p6_valid_rst", 32'(bus.valid_input), 32'd0);
    chk("p6_data_rst",  32'(bus.data_input),  32'd0);
    for (int n = 0; n < 24; n++) step(1'b0, 1'b1, 1'b0);

    // Random traffic: FIFO fill, enable, resync and occasional reset.
    for (int i = 0; i < NR; i++) avail[i] = rd[i];
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 2) == 0) avail[i]++;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
